matmul_16_16_systolic: RTL and testbench

MATMUL_16_16_SYSTOLIC -- requirements
Module: matmul_16_16_systolic

---
 rtl/matmul_16_16_systolic.sv | 273 +++++++++++++++++++++++++++
 tb/tb_matmul_16_16_systolic.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/matmul_16_16_systolic.sv
// rtl/matmul_16_16_systolic.sv - 16x16 output-stationary systolic matrix multiplier
//
// Computes C = A x B over a K-step reduction (K = final_mat_mul_size, 1..S).
// Column k of A and row k of B are fetched in READ step k. They are skewed into an
// SxS array of MAC PEs. C is then drained one row per cycle.
//
// Ports:
//   clk, reset            sole clock; synchronous active-high reset
//   pe_reset              synchronous clear of accumulators and operand pipelines
//   start_mat_mul         level start request, honoured only in IDLE
//   done_mat_mul          high in DONE until start_mat_mul is seen low
//   address_mat_{a,b,c}   base addresses; address_stride_{a,b,c} per-step increments
//   a_addr, b_addr        operand read addresses (READ phase)
//   a_data, b_data        operand read data (column k of A, row k of B)
//   a_data_out/b_data_out masked operands, registered one cycle
//   c_data_out, c_addr    result row and its address; c_data_available marks valid rows
//   validity_mask_*       per-element enables; masked elements enter the array as 0
//   a_data_in, b_data_in, c_data_in, a_loc, b_loc  reserved, ignored
//
// Build option: define MATMUL_SATURATE_EN to saturate products and sums at
// 2^DWIDTH-1. Without it, they wrap modulo 2^DWIDTH.
module matmul_16_16_systolic #(
  parameter int DWIDTH            = 8,
  parameter int MAT_MUL_SIZE      = 16,
  parameter int AWIDTH            = 10,
  parameter int ADDR_STRIDE_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             pe_reset,
  input  logic                             start_mat_mul,
  output logic                             done_mat_mul,
  input  logic [AWIDTH-1:0]                address_mat_a,
  input  logic [AWIDTH-1:0]                address_mat_b,
  input  logic [AWIDTH-1:0]                address_mat_c,
  input  logic [ADDR_STRIDE_WIDTH-1:0]     address_stride_a,
  input  logic [ADDR_STRIDE_WIDTH-1:0]     address_stride_b,
  input  logic [ADDR_STRIDE_WIDTH-1:0]     address_stride_c,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0]   a_data,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0]   b_data,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0]   a_data_in,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0]   b_data_in,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0]   c_data_in,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0]   c_data_out,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0]   a_data_out,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0]   b_data_out,
  output logic [AWIDTH-1:0]                a_addr,
  output logic [AWIDTH-1:0]                b_addr,
  output logic [AWIDTH-1:0]                c_addr,
  output logic                             c_data_available,
  input  logic [MAT_MUL_SIZE-1:0]          validity_mask_a_rows,
  input  logic [MAT_MUL_SIZE-1:0]          validity_mask_a_cols,
  input  logic [MAT_MUL_SIZE-1:0]          validity_mask_b_rows,
  input  logic [MAT_MUL_SIZE-1:0]          validity_mask_b_cols,
  input  logic [7:0]                       final_mat_mul_size,
  input  logic [7:0]                       a_loc,
  input  logic [7:0]                       b_loc
);

  localparam int S  = MAT_MUL_SIZE;
  localparam int SW = $clog2(S);

  typedef enum logic [2:0] {IDLE, READ, COMPUTE, DRAIN, DONE} state_t;

  state_t                 state;
  logic [7:0]             cnt;
  logic [SW-1:0]          kidx;
  logic                   pipe_clr;

  logic [DWIDTH-1:0]      a_in   [S];
  logic [DWIDTH-1:0]      b_in   [S];
  logic [DWIDTH-1:0]      a_skew [S];
  logic [DWIDTH-1:0]      b_skew [S];
  logic [DWIDTH-1:0]      a_h    [S][S];
  logic [DWIDTH-1:0]      b_v    [S][S];
  logic [DWIDTH-1:0]      acc    [S][S];
  logic [SW-1:0]          drain_row;
  logic [S*DWIDTH-1:0]    row_data;
  logic [S*DWIDTH-1:0]    edge_unused_a;
  logic [S*DWIDTH-1:0]    edge_unused_b;

  // Reserved inputs, stride bits above the address width, and the operands
  // leaving the far edge of the array carry no information for this block.
  wire unused_ok = &{1'b0, a_data_in, b_data_in, c_data_in, a_loc, b_loc,
                     address_stride_a[ADDR_STRIDE_WIDTH-1:AWIDTH],
                     address_stride_b[ADDR_STRIDE_WIDTH-1:AWIDTH],
                     address_stride_c[ADDR_STRIDE_WIDTH-1:AWIDTH],
                     edge_unused_a, edge_unused_b};

  assign kidx = cnt[SW-1:0];

  // Starting a job clears the array so the previous result cannot leak in.
  assign pipe_clr = reset || pe_reset || (state == IDLE && start_mat_mul);

  // Operands are forced to zero outside READ so the array only ever sees the
  // K valid steps. Idle cycles inject nothing.
  always_comb begin
    for (int i = 0; i < S; i++) begin
      a_in[i] = '0;
      b_in[i] = '0;
      if (state == READ && validity_mask_a_rows[i] && validity_mask_a_cols[kidx])
        a_in[i] = a_data[i*DWIDTH +: DWIDTH];
      if (state == READ && validity_mask_b_cols[i] && validity_mask_b_rows[kidx])
        b_in[i] = b_data[i*DWIDTH +: DWIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_data_out <= '0;
      b_data_out <= '0;
    end else begin
      for (int i = 0; i < S; i++) begin
        a_data_out[i*DWIDTH +: DWIDTH] <= a_in[i];
        b_data_out[i*DWIDTH +: DWIDTH] <= b_in[i];
      end
    end
  end

  function automatic logic [DWIDTH-1:0] mac(input logic [DWIDTH-1:0] acc_v,
                                            input logic [DWIDTH-1:0] a_v,
                                            input logic [DWIDTH-1:0] b_v_in);
`ifdef MATMUL_SATURATE_EN
    logic [2*DWIDTH-1:0] prod;
    logic [DWIDTH:0]     sum;
    prod = {{DWIDTH{1'b0}}, a_v} * {{DWIDTH{1'b0}}, b_v_in};
    sum  = {1'b0, acc_v} + ((|prod[2*DWIDTH-1:DWIDTH]) ? {1'b0, {DWIDTH{1'b1}}}
                                                       : {1'b0, prod[DWIDTH-1:0]});
    return sum[DWIDTH] ? {DWIDTH{1'b1}} : sum[DWIDTH-1:0];
`else
    logic [DWIDTH-1:0] prod;
    prod = a_v * b_v_in;
    return acc_v + prod;
`endif
  endfunction

  genvar gi, gj;
  generate
    // Row i of A and column i of B are delayed i cycles before entering the array.
    // PE(i,j) then sees step k of both operands together.
    for (gi = 0; gi < S; gi++) begin : g_skew
      if (gi == 0) begin : g_nodly
        assign a_skew[gi] = a_in[gi];
        assign b_skew[gi] = b_in[gi];
      end else begin : g_dly
        logic [DWIDTH-1:0] a_dly [gi];
        logic [DWIDTH-1:0] b_dly [gi];
        always_ff @(posedge clk) begin
          if (pipe_clr) begin
            for (int d = 0; d < gi; d++) begin
              a_dly[d] <= '0;
              b_dly[d] <= '0;
            end
          end else begin
            a_dly[0] <= a_in[gi];
            b_dly[0] <= b_in[gi];
            for (int d = 1; d < gi; d++) begin
              a_dly[d] <= a_dly[d-1];
              b_dly[d] <= b_dly[d-1];
            end
          end
        end
        assign a_skew[gi] = a_dly[gi-1];
        assign b_skew[gi] = b_dly[gi-1];
      end
      assign edge_unused_a[gi*DWIDTH +: DWIDTH] = a_h[gi][S-1];
      assign edge_unused_b[gi*DWIDTH +: DWIDTH] = b_v[S-1][gi];
    end

    for (gi = 0; gi < S; gi++) begin : g_row
      for (gj = 0; gj < S; gj++) begin : g_col
        logic [DWIDTH-1:0] a_op;
        logic [DWIDTH-1:0] b_op;
        if (gj == 0) begin : g_aw
          assign a_op = a_skew[gi];
        end else begin : g_an
          assign a_op = a_h[gi][gj-1];
        end
        if (gi == 0) begin : g_bn
          assign b_op = b_skew[gj];
        end else begin : g_bs
          assign b_op = b_v[gi-1][gj];
        end
        always_ff @(posedge clk) begin
          if (pipe_clr) begin
            a_h[gi][gj] <= '0;
            b_v[gi][gj] <= '0;
            acc[gi][gj] <= '0;
          end else begin
            a_h[gi][gj] <= a_op;
            b_v[gi][gj] <= b_op;
            acc[gi][gj] <= mac(acc[gi][gj], a_op, b_op);
          end
        end
      end
    end
  endgenerate

  // The row loaded into c_data_out at the next edge is row 0 when COMPUTE ends.
  // During DRAIN it is the row after the current one.
  assign drain_row = (state == DRAIN) ? (kidx + SW'(1)) : '0;

  always_comb begin
    row_data = '0;
    for (int j = 0; j < S; j++)
      row_data[j*DWIDTH +: DWIDTH] = acc[drain_row][j];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      a_addr           <= '0;
      b_addr           <= '0;
      c_addr           <= '0;
      c_data_out       <= '0;
      c_data_available <= 1'b0;
      done_mat_mul     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_mat_mul) begin
            state  <= READ;
            cnt    <= '0;
            a_addr <= address_mat_a;
            b_addr <= address_mat_b;
          end
        end
        READ: begin
          if (cnt == final_mat_mul_size - 8'd1) begin
            state <= COMPUTE;
            cnt   <= '0;
          end else begin
            cnt    <= cnt + 8'd1;
            a_addr <= a_addr + address_stride_a[AWIDTH-1:0];
            b_addr <= b_addr + address_stride_b[AWIDTH-1:0];
          end
        end
        COMPUTE: begin
          // The last operand pair reaches PE(S-1,S-1) 2(S-1) cycles after READ ends.
          if (cnt == 8'(2*S-2)) begin
            state            <= DRAIN;
            cnt              <= '0;
            c_data_available <= 1'b1;
            c_data_out       <= row_data;
            c_addr           <= address_mat_c;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DRAIN: begin
          if (cnt == 8'(S-1)) begin
            state            <= DONE;
            c_data_available <= 1'b0;
            done_mat_mul     <= 1'b1;
          end else begin
            cnt        <= cnt + 8'd1;
            c_data_out <= row_data;
            c_addr     <= c_addr + address_stride_c[AWIDTH-1:0];
          end
        end
        DONE: begin
          if (!start_mat_mul) begin
            state        <= IDLE;
            done_mat_mul <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_16_16_systolic.sv
// tb/tb_matmul_16_16_systolic.sv - directed self-checking bench for matmul_16_16_systolic
module tb_matmul_16_16_systolic;

  logic         clk = 1'b0;
  logic         reset;
  logic         pe_reset;
  logic         start_mat_mul;
  logic         done_mat_mul;
  logic [9:0]   address_mat_a, address_mat_b, address_mat_c;
  logic [15:0]  address_stride_a, address_stride_b, address_stride_c;
  logic [127:0] a_data, b_data, a_data_in, b_data_in, c_data_in;
  logic [127:0] c_data_out, a_data_out, b_data_out;
  logic [9:0]   a_addr, b_addr, c_addr;
  logic         c_data_available;
  logic [15:0]  validity_mask_a_rows, validity_mask_a_cols;
  logic [15:0]  validity_mask_b_rows, validity_mask_b_cols;
  logic [7:0]   final_mat_mul_size, a_loc, b_loc;

  int tests = 0;
  int fails = 0;

  matmul_16_16_systolic dut (
    .clk(clk), .reset(reset), .pe_reset(pe_reset),
    .start_mat_mul(start_mat_mul), .done_mat_mul(done_mat_mul),
    .address_mat_a(address_mat_a), .address_mat_b(address_mat_b), .address_mat_c(address_mat_c),
    .address_stride_a(address_stride_a), .address_stride_b(address_stride_b),
    .address_stride_c(address_stride_c),
    .a_data(a_data), .b_data(b_data),
    .a_data_in(a_data_in), .b_data_in(b_data_in), .c_data_in(c_data_in),
    .c_data_out(c_data_out), .a_data_out(a_data_out), .b_data_out(b_data_out),
    .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr),
    .c_data_available(c_data_available),
    .validity_mask_a_rows(validity_mask_a_rows), .validity_mask_a_cols(validity_mask_a_cols),
    .validity_mask_b_rows(validity_mask_b_rows), .validity_mask_b_cols(validity_mask_b_cols),
    .final_mat_mul_size(final_mat_mul_size), .a_loc(a_loc), .b_loc(b_loc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_done"},  {127'd0, done_mat_mul}, 128'd0);
    chk({tag, "_avail"}, {127'd0, c_data_available}, 128'd0);
    chk({tag, "_cdata"}, c_data_out, 128'd0);
    chk({tag, "_adout"}, a_data_out, 128'd0);
    chk({tag, "_bdout"}, b_data_out, 128'd0);
    chk({tag, "_aaddr"}, {118'd0, a_addr}, 128'd0);
    chk({tag, "_baddr"}, {118'd0, b_addr}, 128'd0);
    chk({tag, "_caddr"}, {118'd0, c_addr}, 128'd0);
  endtask

  // One complete job with start held until DONE has been observed. Cycle c is
  // the cycle after the c-th rising edge counted from the start edge.
  task automatic run_job(input int k, input logic [7:0] a_byte, input logic [7:0] b_byte,
                         input logic [15:0] mrows, input logic [9:0] a_base, input int a_str,
                         input logic [7:0] exp_lo, input logic [7:0] exp_hi);
    logic [127:0] exp_ado;
    logic [7:0]   rb;
    int           r;
    final_mat_mul_size   = 8'(k);
    a_data               = {16{a_byte}};
    b_data               = {16{b_byte}};
    validity_mask_a_rows = mrows;
    address_mat_a        = a_base;
    address_stride_a     = 16'(a_str);
    exp_ado              = '0;
    for (int i = 0; i < 16; i++)
      if (mrows[i]) exp_ado[i*8 +: 8] = a_byte;
    start_mat_mul = 1'b1;
    for (int c = 0; c < k + 48; c++) begin
      step();
      if (c < k) begin
        chk("a_addr", {118'd0, a_addr}, {118'd0, 10'(int'(a_base) + c * a_str)});
        chk("b_addr", {118'd0, b_addr}, {118'd0, 10'(c * 16)});
      end
      if (c == 1) chk("a_data_out", a_data_out, exp_ado);
      if (c < k + 31) begin
        chk("avail_low", {127'd0, c_data_available}, 128'd0);
      end else if (c < k + 47) begin
        r  = c - k - 31;
        rb = (r < 8) ? exp_lo : exp_hi;
        chk("avail_high", {127'd0, c_data_available}, 128'd1);
        chk("c_row", c_data_out, {16{rb}});
        chk("c_addr", {118'd0, c_addr}, {118'd0, 10'(r * 16)});
      end else begin
        chk("done_set", {127'd0, done_mat_mul}, 128'd1);
        chk("done_avail", {127'd0, c_data_available}, 128'd0);
        chk("done_cdata", c_data_out, {16{exp_hi}});
      end
    end
    step();
    chk("done_hold", {127'd0, done_mat_mul}, 128'd1);
    start_mat_mul = 1'b0;
    step();
    chk("done_clear", {127'd0, done_mat_mul}, 128'd0);
    step();
    chk("idle_avail", {127'd0, c_data_available}, 128'd0);
  endtask

  initial begin
    reset = 1'b1; pe_reset = 1'b0; start_mat_mul = 1'b0;
    address_mat_a = '0; address_mat_b = '0; address_mat_c = '0;
    address_stride_a = 16'd16; address_stride_b = 16'd16; address_stride_c = 16'd16;
    a_data = '0; b_data = '0; a_data_in = '0; b_data_in = '0; c_data_in = '0;
    validity_mask_a_rows = 16'hFFFF; validity_mask_a_cols = 16'hFFFF;
    validity_mask_b_rows = 16'hFFFF; validity_mask_b_cols = 16'hFFFF;
    final_mat_mul_size = 8'd16; a_loc = '0; b_loc = '0;
    @(negedge clk);
    step(); step(); step();
    chk_all_zero("reset");
    reset = 1'b0;
    step();

    // Baseline: 16 * (1*2) = 0x20 in every element.
    run_job(16, 8'h01, 8'h02, 16'hFFFF, 10'd0, 16, 8'h20, 8'h20);

    // Overflow: 0x10*0x10 = 0x100 per product.
`ifdef MATMUL_SATURATE_EN
    run_job(16, 8'h10, 8'h10, 16'hFFFF, 10'd0, 16, 8'hFF, 8'hFF);
`else
    run_job(16, 8'h10, 8'h10, 16'hFFFF, 10'd0, 16, 8'h00, 8'h00);
`endif

    // A rows 8..15 masked off.
    run_job(16, 8'h01, 8'h02, 16'h00FF, 10'd0, 16, 8'h20, 8'h00);

    // Short job, odd A addressing, then an identical restart.
    run_job(4, 8'h01, 8'h02, 16'hFFFF, 10'd10, 3, 8'h08, 8'h08);
    run_job(4, 8'h01, 8'h02, 16'hFFFF, 10'd10, 3, 8'h08, 8'h08);

    // Reset abort at cycle 20 of a baseline job.
    final_mat_mul_size = 8'd16; a_data = {16{8'h01}}; b_data = {16{8'h02}};
    address_mat_a = '0; address_stride_a = 16'd16;
    start_mat_mul = 1'b1;
    for (int c = 0; c <= 20; c++) step();
    chk("abort_aaddr_live", {118'd0, a_addr}, {118'd0, 10'd240});
    reset = 1'b1;
    start_mat_mul = 1'b0;
    step();
    chk_all_zero("abort");
    reset = 1'b0;
    for (int c = 0; c < 70; c++) begin
      step();
      chk("abort_quiet", {126'd0, c_data_available, done_mat_mul}, 128'd0);
    end
    run_job(4, 8'h01, 8'h02, 16'hFFFF, 10'd10, 3, 8'h08, 8'h08);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
